// File: rtl/axi_wr_addr_master_if.sv
// rtl/axi_wr_addr_master_if.sv - AXI write-address channel bundle plus write-response completion pulse
//
// Purpose : groups the AW channel and the B-completion strobe that the
//           write-address master drives or consumes.
// Signals :
//   awvalid / awready     - AW handshake
//   awid / awaddr / awlen - AW payload (ID, start address, burst length-1)
//   b_done                - one-cycle pulse per completed write response
// Modports:
//   master - drives AW, observes awready and b_done
//   slave  - observes AW, drives awready and b_done
interface axi_wr_addr_master_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8
);
  logic              awvalid;
  logic              awready;
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [LEN_W-1:0]  awlen;
  logic              b_done;

  modport master (
    output awvalid, awid, awaddr, awlen,
    input  awready, b_done
  );

  modport slave (
    input  awvalid, awid, awaddr, awlen,
    output awready, b_done
  );
endinterface

// File: rtl/axi_wr_addr_master.sv
// rtl/axi_wr_addr_master.sv - AXI write-address channel master with command FIFO and outstanding-burst credit
//
// Purpose : accepts write commands on a valid/ready port, queues them in a
//           FIFO and issues them on an AXI AW channel, limiting the number
//           of issued-but-uncompleted bursts to MAX_OUTST.
// Ports   :
//   clk, rst                 - clock, asynchronous active-low reset
//   cmd_valid / cmd_ready    - command request handshake
//   cmd_id/cmd_addr/cmd_len  - command payload
//   aw (master modport)      - AW channel plus b_done completion pulse
//   outst_cnt                - bursts currently outstanding
//   fifo_level               - commands queued (not counting the one on AW)
//   idle                     - nothing queued, nothing presented, nothing outstanding
//   err_underflow            - sticky: b_done seen with nothing outstanding
//   stat_txn_cnt             - AW handshake count (saturating)
//   stat_stall_cnt           - cycles with awvalid & !awready (saturating)
// Option  : define AXI_WR_ADDR_STATS_EN to build the statistics counters;
//           otherwise the stat ports are tied to zero.
module axi_wr_addr_master #(
  parameter int ID_W       = 4,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_OUTST  = 8,
  parameter int CNT_W      = $clog2(MAX_OUTST + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [ID_W-1:0]               cmd_id,
  input  logic [ADDR_W-1:0]             cmd_addr,
  input  logic [LEN_W-1:0]              cmd_len,
  axi_wr_addr_master_if.master          aw,
  output logic [CNT_W-1:0]              outst_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          idle,
  output logic                          err_underflow,
  output logic [31:0]                   stat_txn_cnt,
  output logic [31:0]                   stat_stall_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = ID_W + ADDR_W + LEN_W;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_VALID = 1'b1
  } state_t;

  // Command FIFO: pointers carry one extra wrap bit so full and empty are
  // distinguishable and the difference is directly the occupancy.
  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [PTR_W:0]   level;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [ENT_W-1:0] head;

  // AW output stage
  state_t            state;
  logic              awvalid_r;
  logic [ID_W-1:0]   awid_r;
  logic [ADDR_W-1:0] awaddr_r;
  logic [LEN_W-1:0]  awlen_r;
  logic              hs;

  // Credit counter
  logic [CNT_W-1:0]  cnt_next;
  logic              underflow_now;
  logic              credit_ok_now;
  logic              credit_ok_next;

  assign level     = wr_ptr - rd_ptr;
  assign full      = (level == (PTR_W+1)'(FIFO_DEPTH));
  assign empty     = (level == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rd_ptr[PTR_W-1:0]];

  assign hs = awvalid_r && aw.awready;

  // A handshake and a completion in the same cycle cancel out. A completion
  // with nothing outstanding is flagged and the counter is held at zero.
  always_comb begin
    cnt_next      = outst_cnt;
    underflow_now = 1'b0;
    if (hs && !aw.b_done) begin
      cnt_next = outst_cnt + CNT_W'(1);
    end else if (!hs && aw.b_done) begin
      if (outst_cnt == '0) begin
        underflow_now = 1'b1;
      end else begin
        cnt_next = outst_cnt - CNT_W'(1);
      end
    end
  end

  // From IDLE nothing is presented, so the current count decides. While
  // VALID the presented burst is about to be counted, so the next count
  // decides whether a follow-on burst may be loaded in the same cycle.
  assign credit_ok_now  = (outst_cnt < CNT_W'(MAX_OUTST));
  assign credit_ok_next = (cnt_next < CNT_W'(MAX_OUTST));

  always_comb begin
    pop = 1'b0;
    if (!empty) begin
      if (state == S_IDLE) begin
        pop = credit_ok_now;
      end else begin
        pop = hs && credit_ok_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
    end
  end

  // Storage needs no reset: entries are only read once the pointers say
  // they were written after the last reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[PTR_W-1:0]] <= {cmd_id, cmd_addr, cmd_len};
    end
  end

  // AW stage. awvalid only falls on a handshake, and the payload only
  // changes when a new entry is loaded, so AW stays stable while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      awvalid_r <= 1'b0;
      awid_r    <= '0;
      awaddr_r  <= '0;
      awlen_r   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            {awid_r, awaddr_r, awlen_r} <= head;
            awvalid_r                   <= 1'b1;
            state                       <= S_VALID;
          end
        end
        S_VALID: begin
          if (hs) begin
            if (pop) begin
              {awid_r, awaddr_r, awlen_r} <= head;
            end else begin
              awvalid_r <= 1'b0;
              state     <= S_IDLE;
            end
          end
        end
        default: begin
          state     <= S_IDLE;
          awvalid_r <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outst_cnt     <= '0;
      err_underflow <= 1'b0;
    end else begin
      outst_cnt <= cnt_next;
      if (underflow_now) begin
        err_underflow <= 1'b1;
      end
    end
  end

  assign aw.awvalid = awvalid_r;
  assign aw.awid    = awid_r;
  assign aw.awaddr  = awaddr_r;
  assign aw.awlen   = awlen_r;

  assign fifo_level = level;
  assign idle       = empty && !awvalid_r && (outst_cnt == '0);

`ifdef AXI_WR_ADDR_STATS_EN
  logic [31:0] txn_q;
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      txn_q   <= '0;
      stall_q <= '0;
    end else begin
      if (hs && (txn_q != 32'hFFFF_FFFF)) begin
        txn_q <= txn_q + 32'd1;
      end
      if (awvalid_r && !aw.awready && (stall_q != 32'hFFFF_FFFF)) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign stat_txn_cnt   = txn_q;
  assign stat_stall_cnt = stall_q;
`else
  assign stat_txn_cnt   = 32'd0;
  assign stat_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_axi_wr_addr_master.sv
// tb/tb_axi_wr_addr_master.sv - self-checking bench for axi_wr_addr_master
module tb_axi_wr_addr_master;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_id;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [3:0]  outst_cnt;
  logic [2:0]  fifo_level;
  logic        idle;
  logic        err_underflow;
  logic [31:0] stat_txn_cnt;
  logic [31:0] stat_stall_cnt;

  axi_wr_addr_master_if #(.ID_W(4), .ADDR_W(32), .LEN_W(8)) aw_if ();

  axi_wr_addr_master #(
    .ID_W(4), .ADDR_W(32), .LEN_W(8), .FIFO_DEPTH(4), .MAX_OUTST(8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_id         (cmd_id),
    .cmd_addr       (cmd_addr),
    .cmd_len        (cmd_len),
    .aw             (aw_if),
    .outst_cnt      (outst_cnt),
    .fifo_level     (fifo_level),
    .idle           (idle),
    .err_underflow  (err_underflow),
    .stat_txn_cnt   (stat_txn_cnt),
    .stat_stall_cnt (stat_stall_cnt)
  );

  int errors  = 0;
  int checks  = 0;
  int hs_total = 0;
  int run     = 0;
  int max_run = 0;
  logic [43:0] exp_q[$];
  logic [43:0] exp_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: expected payloads are pushed when a command is accepted and
  // popped when an AW handshake is about to complete (both sampled mid-cycle).
  always @(negedge clk) begin
    if (rst) begin
      if (cmd_valid && cmd_ready) exp_q.push_back({cmd_id, cmd_addr, cmd_len});
      if (aw_if.awvalid && aw_if.awready) begin
        hs_total = hs_total + 1;
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL aw_unexpected got id=%0h addr=%0h len=%0h, no command pending",
                   aw_if.awid, aw_if.awaddr, aw_if.awlen);
        end else begin
          exp_e = exp_q.pop_front();
          if ({aw_if.awid, aw_if.awaddr, aw_if.awlen} !== exp_e) begin
            errors = errors + 1;
            $display("FAIL aw_payload got id=%0h addr=%0h len=%0h expected id=%0h addr=%0h len=%0h",
                     aw_if.awid, aw_if.awaddr, aw_if.awlen, exp_e[43:40], exp_e[39:8], exp_e[7:0]);
          end
        end
      end
      if (aw_if.awvalid) run = run + 1;
      else run = 0;
      if (run > max_run) max_run = run;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic push_cmd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    bit acc;
    acc = 1'b0;
    cmd_valid = 1'b1;
    cmd_id    = id;
    cmd_addr  = addr;
    cmd_len   = len;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL push_accept id=%0d cmd_ready stayed 0, required accept within 50 cycles", id);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (aw_if.awvalid !== 1'b0 || cmd_ready !== 1'b1 || fifo_level !== 3'd0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl got awvalid=%b cmd_ready=%b level=%0d idle=%b required 0 1 0 1",
               aw_if.awvalid, cmd_ready, fifo_level, idle);
    end
    checks++;
    if (outst_cnt !== 4'd0 || err_underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_cnt got outst=%0d err=%b required 0 0", outst_cnt, err_underflow);
    end
    checks++;
    if (aw_if.awid !== 4'd0 || aw_if.awaddr !== 32'd0 || aw_if.awlen !== 8'd0) begin
      errors++;
      $display("FAIL reset_payload got id=%0h addr=%0h len=%0h required 0", aw_if.awid, aw_if.awaddr, aw_if.awlen);
    end
    checks++;
    if (stat_txn_cnt !== 32'd0 || stat_stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_stats got txn=%0d stall=%0d required 0 0", stat_txn_cnt, stat_stall_cnt);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    int hs0;
    hs0 = hs_total;
    aw_if.awready = 1'b1;
    max_run = 0;
    for (int i = 0; i < 10; i++) push_cmd(4'(i), 32'(i * 32'h1000), 8'(i));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (aw_if.awvalid !== 1'b0 || outst_cnt !== 4'd8) begin
        errors++;
        $display("FAIL stream_credit_stall got awvalid=%b outst=%0d required 0 8", aw_if.awvalid, outst_cnt);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (hs_total - hs0 !== 8 || fifo_level !== 3'd2) begin
      errors++;
      $display("FAIL stream_issued got handshakes=%0d level=%0d required 8 2", hs_total - hs0, fifo_level);
    end
    checks++;
    if (max_run !== 8) begin
      errors++;
      $display("FAIL stream_back_to_back got awvalid run=%0d required 8", max_run);
    end
    tick();
  endtask

  task automatic test_credit();
    aw_if.b_done = 1'b1;
    tick();
    aw_if.b_done = 1'b0;
    @(negedge clk);
    checks++;
    if (outst_cnt !== 4'd7 || aw_if.awvalid !== 1'b0) begin
      errors++;
      $display("FAIL credit_release got outst=%0d awvalid=%b required 7 0", outst_cnt, aw_if.awvalid);
    end
    tick();
    aw_if.b_done = 1'b1;
    @(negedge clk);
    checks++;
    if (aw_if.awvalid !== 1'b1 || aw_if.awid !== 4'd8 || outst_cnt !== 4'd7) begin
      errors++;
      $display("FAIL credit_reissue got awvalid=%b id=%0d outst=%0d required 1 8 7",
               aw_if.awvalid, aw_if.awid, outst_cnt);
    end
    tick();
    aw_if.b_done = 1'b0;
    @(negedge clk);
    checks++;
    if (outst_cnt !== 4'd7 || aw_if.awvalid !== 1'b1 || aw_if.awid !== 4'd9) begin
      errors++;
      $display("FAIL credit_simultaneous got outst=%0d awvalid=%b id=%0d required 7 1 9",
               outst_cnt, aw_if.awvalid, aw_if.awid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (outst_cnt !== 4'd8 || aw_if.awvalid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL credit_full got outst=%0d awvalid=%b pending=%0d required 8 0 0",
               outst_cnt, aw_if.awvalid, exp_q.size());
    end
    tick();
    aw_if.b_done = 1'b1;
    repeat (8) tick();
    aw_if.b_done = 1'b0;
    @(negedge clk);
    checks++;
    if (outst_cnt !== 4'd0 || idle !== 1'b1 || err_underflow !== 1'b0) begin
      errors++;
      $display("FAIL credit_drain got outst=%0d idle=%b err=%b required 0 1 0", outst_cnt, idle, err_underflow);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int hs0;
    hs0 = hs_total;
    aw_if.awready = 1'b0;
    push_cmd(4'd3, 32'hABCD_0000, 8'd5);
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (aw_if.awvalid !== 1'b1 || aw_if.awid !== 4'd3 || aw_if.awaddr !== 32'hABCD_0000 || aw_if.awlen !== 8'd5) begin
        errors++;
        $display("FAIL bp_stable cycle=%0d got valid=%b id=%0h addr=%0h len=%0h required 1 3 abcd0000 5",
                 k, aw_if.awvalid, aw_if.awid, aw_if.awaddr, aw_if.awlen);
      end
      tick();
    end
    aw_if.awready = 1'b1;
    tick();
    aw_if.awready = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if (hs_total - hs0 !== 1 || aw_if.awvalid !== 1'b0 || outst_cnt !== 4'd1) begin
      errors++;
      $display("FAIL bp_single_hs got handshakes=%0d awvalid=%b outst=%0d required 1 0 1",
               hs_total - hs0, aw_if.awvalid, outst_cnt);
    end
    checks++;
`ifdef AXI_WR_ADDR_STATS_EN
    if (stat_stall_cnt !== 32'd5 || stat_txn_cnt !== 32'd11) begin
      errors++;
      $display("FAIL bp_stats got stall=%0d txn=%0d required 5 11", stat_stall_cnt, stat_txn_cnt);
    end
`else
    if (stat_stall_cnt !== 32'd0 || stat_txn_cnt !== 32'd0) begin
      errors++;
      $display("FAIL bp_stats got stall=%0d txn=%0d required 0 0", stat_stall_cnt, stat_txn_cnt);
    end
`endif
    aw_if.b_done = 1'b1;
    tick();
    aw_if.b_done = 1'b0;
  endtask

  task automatic test_fifo_full();
    int hs0;
    hs0 = hs_total;
    aw_if.awready = 1'b0;
    for (int i = 0; i < 5; i++) push_cmd(4'(10 + i), 32'h2000_0000 + 32'(i * 64), 8'(i + 1));
    cmd_valid = 1'b1;
    cmd_id    = 4'd15;
    cmd_addr  = 32'h2000_0140;
    cmd_len   = 8'd6;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b0 || fifo_level !== 3'd4 || aw_if.awid !== 4'd10) begin
        errors++;
        $display("FAIL full_hold cycle=%0d got cmd_ready=%b level=%0d awid=%0d required 0 4 10",
                 k, cmd_ready, fifo_level, aw_if.awid);
      end
      tick();
    end
    aw_if.awready = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_simul_push got cmd_ready=%b required 0", cmd_ready);
    end
    tick();
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || fifo_level !== 3'd3) begin
      errors++;
      $display("FAIL full_release got cmd_ready=%b level=%0d required 1 3", cmd_ready, fifo_level);
    end
    tick();
    cmd_valid = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    checks++;
    if (hs_total - hs0 !== 6 || exp_q.size() != 0 || outst_cnt !== 4'd6 || aw_if.awvalid !== 1'b0) begin
      errors++;
      $display("FAIL full_drain got handshakes=%0d pending=%0d outst=%0d awvalid=%b required 6 0 6 0",
               hs_total - hs0, exp_q.size(), outst_cnt, aw_if.awvalid);
    end
    tick();
    aw_if.awready = 1'b0;
    aw_if.b_done  = 1'b1;
    repeat (6) tick();
    aw_if.b_done  = 1'b0;
  endtask

  task automatic test_underflow();
    do_reset();
    @(negedge clk);
    checks++;
    if (outst_cnt !== 4'd0 || err_underflow !== 1'b0) begin
      errors++;
      $display("FAIL uf_base got outst=%0d err=%b required 0 0", outst_cnt, err_underflow);
    end
    tick();
    aw_if.b_done = 1'b1;
    tick();
    aw_if.b_done = 1'b0;
    @(negedge clk);
    checks++;
    if (outst_cnt !== 4'd0 || err_underflow !== 1'b1) begin
      errors++;
      $display("FAIL uf_set got outst=%0d err=%b required 0 1", outst_cnt, err_underflow);
    end
    repeat (5) tick();
    @(negedge clk);
    checks++;
    if (err_underflow !== 1'b1 || outst_cnt !== 4'd0) begin
      errors++;
      $display("FAIL uf_sticky got err=%b outst=%0d required 1 0", err_underflow, outst_cnt);
    end
    tick();
  endtask

  task automatic test_async_reset();
    int hs0;
    bit seen;
    aw_if.awready = 1'b0;
    push_cmd(4'd1, 32'h0000_0100, 8'd1);
    push_cmd(4'd2, 32'h0000_0200, 8'd2);
    push_cmd(4'd3, 32'h0000_0300, 8'd3);
    @(negedge clk);
    checks++;
    if (aw_if.awvalid !== 1'b1 || fifo_level !== 3'd2) begin
      errors++;
      $display("FAIL ar_pre got awvalid=%b level=%0d required 1 2", aw_if.awvalid, fifo_level);
    end
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (aw_if.awvalid !== 1'b0 || cmd_ready !== 1'b1 || fifo_level !== 3'd0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL ar_immediate got awvalid=%b cmd_ready=%b level=%0d idle=%b required 0 1 0 1",
               aw_if.awvalid, cmd_ready, fifo_level, idle);
    end
    checks++;
    if (err_underflow !== 1'b0 || stat_txn_cnt !== 32'd0 || stat_stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL ar_clear got err=%b txn=%0d stall=%0d required 0 0 0", err_underflow, stat_txn_cnt, stat_stall_cnt);
    end
    tick();
    tick();
    rst = 1'b1;
    tick();
    hs0 = hs_total;
    push_cmd(4'd7, 32'h55AA_0000, 8'd3);
    aw_if.awready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (hs_total != hs0) seen = 1'b1;
    end
    tick();
    aw_if.awready = 1'b0;
    checks++;
    if (!seen || exp_q.size() != 0) begin
      errors++;
      $display("FAIL ar_post_issue got handshake=%b pending=%0d required 1 0", seen, exp_q.size());
    end
  endtask

  initial begin
    rst           = 1'b0;
    cmd_valid     = 1'b0;
    cmd_id        = '0;
    cmd_addr      = '0;
    cmd_len       = '0;
    aw_if.awready = 1'b0;
    aw_if.b_done  = 1'b0;
    test_reset();
    test_stream();
    test_credit();
    test_backpressure();
    test_fifo_full();
    test_underflow();
    test_async_reset();
    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
